// File: rtl/wb_axi_write_ctrl.sv
// Write-path arbiter: grants uncached stores or write-buffer line drains
// onto one AXI write channel, one transaction at a time.
// Ports: clk, rst (sync, active-low); uc_* uncached store request/done;
//   wb_* write-buffer drain request/done; judge_o owner; AXI AW/W/B; err_o.
module wb_axi_write_ctrl #(
  parameter int UC_PRIORITY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         uc_req_i,
  input  logic [31:0]  uc_addr_i,
  input  logic [31:0]  uc_data_i,
  input  logic [3:0]   uc_wstrb_i,
  output logic         uc_done_o,
  input  logic         wb_req_i,
  input  logic [31:0]  wb_addr_i,
  input  logic [127:0] wb_data_i,
  output logic         wb_done_o,
  output logic [1:0]   judge_o,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready,
  output logic         err_o
);

  typedef enum logic [1:0] {
    S_IDLE, S_AW, S_W, S_B
  } state_t;

  state_t       state;
  logic [1:0]   cnt;
  logic [127:0] line;
  logic         pick_uc;
  logic         can_grant;

  assign pick_uc = uc_req_i &&
                   ((UC_PRIORITY != 0) || !wb_req_i);

  // A done pulse means the requester has not yet seen completion,
  // so its level request is stale for this cycle.
  assign can_grant = (uc_req_i || wb_req_i) &&
                     !uc_done_o && !wb_done_o;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      line      <= '0;
      judge_o   <= 2'b00;
      awaddr    <= '0;
      awlen     <= '0;
      awsize    <= 3'b010;
      awburst   <= 2'b01;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wlast     <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      uc_done_o <= 1'b0;
      wb_done_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      uc_done_o <= 1'b0;
      wb_done_o <= 1'b0;
      err_o     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (can_grant) begin
            if (pick_uc) begin
              judge_o <= 2'b01;
              awaddr  <= uc_addr_i;
              awlen   <= 8'd0;
              wstrb   <= uc_wstrb_i;
              line    <= {96'b0, uc_data_i};
            end else begin
              judge_o <= 2'b10;
              awaddr  <= wb_addr_i;
              awlen   <= 8'd3;
              wstrb   <= 4'b1111;
              line    <= wb_data_i;
            end
            awsize  <= 3'b010;
            awburst <= 2'b01;
            awvalid <= 1'b1;
            cnt     <= 2'd0;
            state   <= S_AW;
          end
        end
        S_AW: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wdata   <= line[31:0];
            wlast   <= (awlen == 8'd0);
            state   <= S_W;
          end
        end
        S_W: begin
          if (wready) begin
            if (wlast) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              state  <= S_B;
            end else begin
              // Line shifts down one word per accepted beat.
              cnt   <= cnt + 2'd1;
              line  <= {32'b0, line[127:32]};
              wdata <= line[63:32];
              wlast <= ((cnt + 2'd1) == awlen[1:0]);
            end
          end
        end
        S_B: begin
          if (bvalid) begin
            bready    <= 1'b0;
            uc_done_o <= (judge_o == 2'b01);
            wb_done_o <= (judge_o == 2'b10);
            err_o     <= (bresp != 2'b00);
            judge_o   <= 2'b00;
            cnt       <= 2'd0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
